// File: rtl/hilo_div_ctrl.sv
// HI/LO register file and sequencer for the iterative divider: issue, stall, div-by-zero, capture, mthi/mtlo.
// Optional macro HILO_BYPASS_EN makes hi/lo forward accepted writes and captured results combinationally.
module hilo_div_ctrl #(
    parameter int DIV_LATENCY = 36
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_start,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wr_data,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    input  logic        div_by_zero,
    output logic        div_op,
    output logic        busy,
    output logic        div_zero_exc,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(DIV_LATENCY);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CHECK   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          wr_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (div_start) state_nxt = ISSUE;
            ISSUE:   state_nxt = CHECK;
            CHECK:   state_nxt = div_by_zero ? IDLE : WAIT;
            WAIT:    if (cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // div_by_zero is only meaningful in CHECK; the divider self-clears it afterwards.
    always_comb begin
        div_op       = (state == ISSUE);
        busy         = (state != IDLE);
        div_zero_exc = (state == CHECK) && div_by_zero;
    end

    assign wr_ok = !busy;

    // Loaded with DIV_LATENCY-2 so CAPTURE lines up with the single valid-result cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == CHECK && !div_by_zero) begin
            cnt <= CW'(DIV_LATENCY - 2);
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == CAPTURE);
            if (state == CAPTURE) begin
                lo_q <= div_quotient;
                hi_q <= div_remainder;
            end else if (wr_ok) begin
                if (mthi) hi_q <= wr_data;
                if (mtlo) lo_q <= wr_data;
            end
        end
    end

`ifdef HILO_BYPASS_EN
    always_comb begin
        hi = hi_q;
        lo = lo_q;
        if (state == CAPTURE) begin
            hi = div_remainder;
            lo = div_quotient;
        end else if (wr_ok) begin
            if (mthi) hi = wr_data;
            if (mtlo) lo = wr_data;
        end
    end
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule
